// File: rtl/exu_alu_pipe.sv
// Registered XLEN-bit integer ALU between dispatch and writeback, one-hot op select, optional iterative shifter.
// Latency: 1 cycle for every op; iterative shifts take 1 + ceil(shamt/SHIFT_STEP) cycles.
// Backpressure: the result is held stable until res_ready_i; a new request is taken only when idle or while retiring.
module exu_alu_pipe #(
    parameter int XLEN       = 32,
    parameter int SHAMT_W    = $clog2(XLEN),
    parameter int SHIFT_ITER = 0,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] alu_op1_i,
    input  logic [XLEN-1:0] alu_op2_i,
    input  logic [9:0]      alu_op_i,
    input  logic [4:0]      alu_rd_i,
    input  logic            flush_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            reg_we_o,
    output logic [4:0]      reg_waddr_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD} state_t;
    typedef enum logic [3:0] {
        OP_NONE, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_sel_t;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} sh_kind_t;

    // One step may be as wide as XLEN, so it needs one more bit than a shift amount.
    localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W+1)'(SHIFT_STEP);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   sh_val_q, sh_val_d;
    logic [SHAMT_W-1:0] sh_rem_q, sh_rem_d;
    sh_kind_t          sh_kind_q, sh_kind_d;

    op_sel_t           op_sel;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]   alu_res;
    logic              op_is_shift;
    logic              iter_start;
    logic              accept;
    logic [SHAMT_W-1:0] sh_step;
    logic [SHAMT_W-1:0] sh_rem_nxt;
    logic [XLEN-1:0]   sh_shifted;

    assign shamt       = alu_op2_i[SHAMT_W-1:0];
    assign req_ready_o = !rst && !flush_i &&
                         ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && res_ready_i));
    assign accept      = req_valid_i && req_ready_o;

    assign res_valid_o = (state_q == ST_HOLD);
    assign busy_o      = (state_q == ST_SHIFT);
    assign result_o    = result_q;
    assign reg_waddr_o = rd_q;
    assign reg_we_o    = res_valid_o && (rd_q != 5'd0);

    // Collapse a multi-hot op vector to a single op using the fixed priority order.
    always_comb begin
        op_sel = OP_NONE;
        if      (alu_op_i[5]) op_sel = OP_XOR;
        else if (alu_op_i[8]) op_sel = OP_OR;
        else if (alu_op_i[9]) op_sel = OP_AND;
        else if (alu_op_i[0]) op_sel = OP_ADD;
        else if (alu_op_i[1]) op_sel = OP_SUB;
        else if (alu_op_i[2]) op_sel = OP_SLL;
        else if (alu_op_i[6]) op_sel = OP_SRL;
        else if (alu_op_i[7]) op_sel = OP_SRA;
        else if (alu_op_i[3]) op_sel = OP_SLT;
        else if (alu_op_i[4]) op_sel = OP_SLTU;
    end

    // Single-cycle datapath, including the full barrel shift.
    always_comb begin
        alu_res = '0;
        case (op_sel)
            OP_ADD:  alu_res = alu_op1_i + alu_op2_i;
            OP_SUB:  alu_res = alu_op1_i - alu_op2_i;
            OP_SLL:  alu_res = alu_op1_i << shamt;
            OP_SRL:  alu_res = alu_op1_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(alu_op1_i) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_op1_i) < $signed(alu_op2_i))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (alu_op1_i < alu_op2_i)};
            OP_XOR:  alu_res = alu_op1_i ^ alu_op2_i;
            OP_OR:   alu_res = alu_op1_i | alu_op2_i;
            OP_AND:  alu_res = alu_op1_i & alu_op2_i;
            default: alu_res = '0;
        endcase
    end

    assign op_is_shift = (op_sel == OP_SLL) || (op_sel == OP_SRL) || (op_sel == OP_SRA);
    // A zero-amount shift is just op1, so it takes the single-cycle path.
    assign iter_start  = (SHIFT_ITER != 0) && op_is_shift && (shamt != '0);

    // One iterative shift step: move by the smaller of the remaining amount and SHIFT_STEP.
    always_comb begin
        sh_step = ({1'b0, sh_rem_q} < STEP_C) ? sh_rem_q : STEP_C[SHAMT_W-1:0];
        sh_rem_nxt = sh_rem_q - sh_step;
        case (sh_kind_q)
            SH_SLL:  sh_shifted = sh_val_q << sh_step;
            SH_SRL:  sh_shifted = sh_val_q >> sh_step;
            default: sh_shifted = $unsigned($signed(sh_val_q) >>> sh_step);
        endcase
    end

    // Next-state logic: flush wins over everything, then retire/shift progress, then accept.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        rd_d      = rd_q;
        sh_val_d  = sh_val_q;
        sh_rem_d  = sh_rem_q;
        sh_kind_d = sh_kind_q;
        if (flush_i) begin
            state_d  = ST_IDLE;
            result_d = '0;
            rd_d     = '0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    sh_val_d = sh_shifted;
                    sh_rem_d = sh_rem_nxt;
                    if (sh_rem_nxt == '0) begin
                        state_d  = ST_HOLD;
                        result_d = sh_shifted;
                    end
                end
                ST_HOLD: begin
                    if (res_ready_i) state_d = ST_IDLE;
                end
                default: ;
            endcase
            if (accept) begin
                rd_d = alu_rd_i;
                if (iter_start) begin
                    state_d  = ST_SHIFT;
                    sh_val_d = alu_op1_i;
                    sh_rem_d = shamt;
                    if (op_sel == OP_SLL)      sh_kind_d = SH_SLL;
                    else if (op_sel == OP_SRL) sh_kind_d = SH_SRL;
                    else                       sh_kind_d = SH_SRA;
                end else begin
                    state_d  = ST_HOLD;
                    result_d = alu_res;
                end
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            rd_q      <= '0;
            sh_val_q  <= '0;
            sh_rem_q  <= '0;
            sh_kind_q <= SH_SLL;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            sh_val_q  <= sh_val_d;
            sh_rem_q  <= sh_rem_d;
            sh_kind_q <= sh_kind_d;
        end
    end

endmodule

// File: tb/tb_exu_alu_pipe.sv
// Scoreboarded bench for exu_alu_pipe in iterative-shift mode (XLEN=32, SHIFT_STEP=4).
// Directed cases cover latency, backpressure, flush and reset; a random phase follows.
// Results are compared at retirement against a plain-arithmetic reference model.
module tb_exu_alu_pipe;

    localparam logic [9:0] OP_ADD  = 10'b0000000001;
    localparam logic [9:0] OP_SUB  = 10'b0000000010;
    localparam logic [9:0] OP_SLL  = 10'b0000000100;
    localparam logic [9:0] OP_SLT  = 10'b0000001000;
    localparam logic [9:0] OP_SLTU = 10'b0000010000;
    localparam logic [9:0] OP_XOR  = 10'b0000100000;
    localparam logic [9:0] OP_SRA  = 10'b0010000000;
    localparam logic [9:0] OP_OR   = 10'b0100000000;
    localparam logic [9:0] OP_AND  = 10'b1000000000;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] alu_op1_i;
    logic [31:0] alu_op2_i;
    logic [9:0]  alu_op_i;
    logic [4:0]  alu_rd_i;
    logic        flush_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] result_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic        busy_o;

    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;
    bit   rand_rdy = 1'b0;
    exp_t sb[$];

    exu_alu_pipe #(
        .XLEN(32), .SHIFT_ITER(1), .SHIFT_STEP(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .alu_op1_i(alu_op1_i), .alu_op2_i(alu_op2_i),
        .alu_op_i(alu_op_i), .alu_rd_i(alu_rd_i),
        .flush_i(flush_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .result_o(result_o), .reg_we_o(reg_we_o),
        .reg_waddr_o(reg_waddr_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference ALU: walk the priority list, apply the first op whose bit is set.
    function automatic logic [31:0] ref_alu(input logic [9:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int prio[10];
        int sh;
        prio = '{5, 8, 9, 0, 1, 2, 6, 7, 3, 4};
        sh = int'(b[4:0]);
        for (int i = 0; i < 10; i++) begin
            if (op[prio[i]]) begin
                case (prio[i])
                    0: return a + b;
                    1: return a - b;
                    2: return a << sh;
                    3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    4: return (a < b) ? 32'd1 : 32'd0;
                    5: return a ^ b;
                    6: return a >> sh;
                    7: return a[31] ? ~((~a) >> sh) : (a >> sh);
                    8: return a | b;
                    default: return a & b;
                endcase
            end
        end
        return 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request until accepted; push the reference result when it is taken.
    task automatic issue(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int acc_cyc);
        logic rdy;
        exp_t e;
        req_valid_i = 1'b1;
        alu_op_i    = op;
        alu_op1_i   = a;
        alu_op2_i   = b;
        alu_rd_i    = rd;
        acc_cyc     = -1;
        for (int i = 0; i < 100 && acc_cyc < 0; i++) begin
            @(negedge clk);
            rdy = req_ready_o;
            tick();
            if (rdy) begin
                acc_cyc = cycle;
                e.res = ref_alu(op, a, b);
                e.rd  = rd;
                sb.push_back(e);
            end
        end
        req_valid_i = 1'b0;
        if (acc_cyc < 0) check("issue_timeout", 32'd0, 32'd1);
    endtask

    // Result expected on the very next cycle after accept.
    task automatic expect_now(input string name, input logic [31:0] exp);
        @(negedge clk);
        check({name, "_valid"}, 32'(res_valid_o), 32'd1);
        check({name, "_result"}, result_o, exp);
        tick();
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        @(negedge clk);
        tick();
        flush_i = 1'b0;
        sb.delete();
    endtask

    // Monitor: every retired result must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && !flush_i && res_valid_o && res_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_result", result_o, 32'hDEAD_BEEF);
            end else begin
                e = sb.pop_front();
                check("sb_result", result_o, e.res);
                check("sb_waddr", 32'(reg_waddr_o), 32'(e.rd));
                check("sb_we", 32'(reg_we_o), 32'(e.rd != 5'd0));
            end
        end
    end

    // Random consumer backpressure during the random phase.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            res_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int cyc[4];
        logic [9:0] op;
        rst = 1'b1; req_valid_i = 1'b0; alu_op1_i = '0; alu_op2_i = '0;
        alu_op_i = '0; alu_rd_i = '0; flush_i = 1'b0; res_ready_i = 1'b1;

        // Reset state
        tick();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_res_valid", 32'(res_valid_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_we", 32'(reg_we_o), 32'd0);
        check("rst_waddr", 32'(reg_waddr_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready_o), 32'd1);
        tick();

        // Single-cycle ops
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd5, c);
        @(negedge clk);
        check("add_valid", 32'(res_valid_o), 32'd1);
        check("add_result", result_o, 32'h8000_0000);
        check("add_we", 32'(reg_we_o), 32'd1);
        check("add_waddr", 32'(reg_waddr_o), 32'd5);
        tick();
        issue(OP_SUB, 32'd3, 32'd5, 5'd9, c);
        expect_now("sub", 32'hFFFF_FFFE);
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd10, c);
        expect_now("slt_neg", 32'd1);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd11, c);
        expect_now("sltu", 32'd0);
        issue(OP_SLT, 32'd5, 32'd5, 5'd0, c);
        @(negedge clk);
        check("slt_eq_valid", 32'(res_valid_o), 32'd1);
        check("slt_eq_result", result_o, 32'd0);
        check("rd0_we", 32'(reg_we_o), 32'd0);
        tick();

        // Backpressure then back-to-back throughput
        res_ready_i = 1'b0;
        issue(OP_OR, 32'h0000_F0F0, 32'h0000_0F0F, 5'd7, c);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(res_valid_o), 32'd1);
            check("bp_result", result_o, 32'h0000_FFFF);
            check("bp_waddr", 32'(reg_waddr_o), 32'd7);
            check("bp_req_ready", 32'(req_ready_o), 32'd0);
            tick();
        end
        res_ready_i = 1'b1;
        for (int i = 0; i < 4; i++)
            issue(OP_XOR, 32'h1111_0000 * (i + 1), 32'h0F0F_0F0F, 5'(i + 1), cyc[i]);
        for (int i = 1; i < 4; i++) check("stream_cycle", 32'(cyc[i] - cyc[0]), 32'(i));
        expect_now("stream_last", ref_alu(OP_XOR, 32'h4444_0000, 32'h0F0F_0F0F));

        // Iterative shift: 13 = 4+4+4+1 -> four busy cycles
        issue(OP_SRA, 32'h8000_0000, 32'd13, 5'd12, c);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("sra_busy", 32'(busy_o), 32'(k <= 4));
            check("sra_valid", 32'(res_valid_o), 32'(k == 5));
            if (k == 5) check("sra_result", result_o, 32'hFFFC_0000);
            tick();
        end
        issue(OP_SLL, 32'h1234_5678, 32'h0000_0020, 5'd13, c);
        @(negedge clk);
        check("sll0_busy", 32'(busy_o), 32'd0);
        check("sll0_valid", 32'(res_valid_o), 32'd1);
        check("sll0_result", result_o, 32'h1234_5678);
        tick();

        // Flush in the second shift cycle
        issue(OP_SLL, 32'h0000_00A5, 32'd20, 5'd3, c);
        @(negedge clk);
        check("fl_sh_busy1", 32'(busy_o), 32'd1);
        tick();
        do_flush();
        @(negedge clk);
        check("fl_sh_valid", 32'(res_valid_o), 32'd0);
        check("fl_sh_busy", 32'(busy_o), 32'd0);
        check("fl_sh_result", result_o, 32'd0);
        check("fl_sh_req_ready", 32'(req_ready_o), 32'd1);
        tick();

        // Flush a held result while a request is presented
        res_ready_i = 1'b0;
        issue(OP_ADD, 32'd1, 32'd2, 5'd4, c);
        req_valid_i = 1'b1; alu_op_i = OP_ADD; alu_op1_i = 32'd10; alu_op2_i = 32'd10;
        alu_rd_i = 5'd6; flush_i = 1'b1;
        @(negedge clk);
        check("fl_hold_req_ready", 32'(req_ready_o), 32'd0);
        tick();
        flush_i = 1'b0; req_valid_i = 1'b0; sb.delete();
        @(negedge clk);
        check("fl_hold_valid", 32'(res_valid_o), 32'd0);
        check("fl_hold_we", 32'(reg_we_o), 32'd0);
        check("fl_hold_waddr", 32'(reg_waddr_o), 32'd0);
        res_ready_i = 1'b1;
        tick();

        // Multi-hot and empty op vectors
        issue(10'b0000100001, 32'd6, 32'd3, 5'd1, c);
        expect_now("multihot", 32'd5);
        issue(10'b0000000000, 32'd7, 32'd8, 5'd2, c);
        expect_now("zero_op", 32'd0);

        // Random traffic with random backpressure and occasional flushes
        rand_rdy = 1'b1;
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                do_flush();
            end else begin
                if ($urandom_range(0, 7) == 0) op = 10'($urandom_range(0, 1023));
                else op = 10'b1 << $urandom_range(0, 9);
                issue(op, $urandom, $urandom, 5'($urandom_range(0, 31)), c);
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        rand_rdy = 1'b0;
        tick();
        res_ready_i = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);

        // Reset clears a held result
        res_ready_i = 1'b0;
        issue(OP_AND, 32'h0000_00FF, 32'h0000_000F, 5'd8, c);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_req_ready", 32'(req_ready_o), 32'd0);
        tick();
        rst = 1'b0; sb.delete();
        @(negedge clk);
        check("rst2_valid", 32'(res_valid_o), 32'd0);
        check("rst2_result", result_o, 32'd0);
        check("rst2_waddr", 32'(reg_waddr_o), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
